// File: rtl/seq_pkg.sv
// Shared types and defaults for the serial scan controller and its match core.
package seq_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int PAT_W_DEF  = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    // Folds an out-of-range pattern length into 1..max_len.
    function automatic int clamp_len(input int len, input int max_len);
        if (len < 1)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit history shift register with a length-masked pattern compare; match is registered
// and reflects the history including the bit shifted in on the previous cycle.
module seq_match_core
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    output logic             match
);

    // Only PAT_W-1 past bits need storing; the incoming bit completes the window.
    logic [PAT_W-2:0] hist_q;
    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] seen_q;
    logic [LEN_W-1:0] seen_nxt;
    logic             hit;

    // NOTE: every signal written in always_comb gets a value before any branch,
    // otherwise synthesis infers a latch to hold it.
    always_comb begin
        hist_nxt = {hist_q, bit_in};
        seen_nxt = (seen_q >= pat_len) ? seen_q : seen_q + 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(pat_len));
        end
        hit = (seen_nxt >= pat_len) && (((hist_nxt ^ pattern) & mask) == '0);
    end

    // NOTE: registers are updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist_q <= '0;
            seen_q <= '0;
            match  <= 1'b0;
        end else if (shift_en) begin
            hist_q <= hist_nxt[PAT_W-2:0];
            seen_q <= seen_nxt;
            match  <= hit;
        end else begin
            match  <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit scan controller: handshake, MSB-first serialiser, match counting and stop logic.
// Optional SEQ_SCAN_FIRST_POS_EN adds first_pos, the stream index of the first match's last bit.
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int PAT_W  = PAT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PAT_W-1:0]      pattern,
    input  logic [$clog2(PAT_W):0] pat_len,
    input  logic [CNT_W-1:0]      match_limit,
    input  logic                  in_valid,
    input  logic [WORD_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  match_pulse,
    output logic [CNT_W-1:0]      match_count,
    output logic                  done
`ifdef SEQ_SCAN_FIRST_POS_EN
    ,
    output logic [31:0]           first_pos
`endif
);

    localparam int LEN_W  = $clog2(PAT_W) + 1;
    localparam int BIDX_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    scan_state_e       state;
    scan_state_e       state_nxt;
    logic [WORD_W-1:0] word_q;
    logic [BIDX_W-1:0] bit_idx;
    logic [PAT_W-1:0]  pattern_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_eff;
    logic [CNT_W-1:0]  limit_q;
    logic [CNT_W-1:0]  count_q;
    logic              start_scan;
    logic              accept;
    logic              shift_en;
    logic              limit_hit;
    logic              stop;
    logic              match;

    always_comb begin
        start_scan  = (state == IDLE) && start;
        in_ready    = (state == LOAD);
        busy        = (state == LOAD) || (state == SHIFT);
        done        = (state == DONE);
        match_pulse = match;
        len_eff     = LEN_W'(clamp_len(int'(pat_len), PAT_W));
        // count_q trails the pulse by a cycle; folding match in here makes the
        // visible count step in the same cycle as match_pulse.
        match_count = (match && (count_q != CNT_MAX)) ? count_q + 1'b1 : count_q;
        limit_hit   = match && (limit_q != '0) && (match_count == limit_q);
        stop        = busy && (abort || limit_hit);
        accept      = in_valid && in_ready && !stop;
        shift_en    = (state == SHIFT) && !stop;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start_scan) state_nxt = LOAD;
            LOAD: begin
                if (stop)
                    state_nxt = DONE;
                else if (in_valid)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                if (stop)
                    state_nxt = DONE;
                else if (bit_idx == '0)
                    state_nxt = LOAD;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word_q    <= '0;
            bit_idx   <= '0;
            pattern_q <= '0;
            len_q     <= LEN_W'(1);
            limit_q   <= '0;
            count_q   <= '0;
        end else begin
            state <= state_nxt;
            if (start_scan) begin
                pattern_q <= pattern;
                len_q     <= len_eff;
                limit_q   <= match_limit;
                count_q   <= '0;
            end else begin
                count_q   <= match_count;
            end
            if (accept) begin
                word_q  <= in_data;
                bit_idx <= BIDX_W'(WORD_W - 1);
            end else if (shift_en) begin
                bit_idx <= bit_idx - 1'b1;
            end
        end
    end

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_scan),
        .shift_en (shift_en),
        .bit_in   (word_q[bit_idx]),
        .pattern  (pattern_q),
        .pat_len  (len_q),
        .match    (match)
    );

`ifdef SEQ_SCAN_FIRST_POS_EN
    logic [31:0] pos_cnt;

    // During a match cycle pos_cnt already includes the completing bit.
    always_ff @(posedge clk) begin
        if (rst || start_scan) begin
            pos_cnt   <= '0;
            first_pos <= '1;
        end else begin
            if (shift_en)
                pos_cnt <= pos_cnt + 1'b1;
            if (match && (first_pos == '1))
                first_pos <= pos_cnt - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: a table of whole scans plus hand-written corner sequences.
module tb_seq_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  pattern;
    logic [3:0]  pat_len;
    logic [15:0] match_limit;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        busy;
    logic        match_pulse;
    logic [15:0] match_count;
    logic        done;
`ifdef SEQ_SCAN_FIRST_POS_EN
    logic [31:0] first_pos;
`endif

    seq_scan_ctrl #(.WORD_W(8), .PAT_W(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .match_limit (match_limit),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .done        (done)
`ifdef SEQ_SCAN_FIRST_POS_EN
        ,
        .first_pos   (first_pos)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int pulse_total = 0;
    int done_total  = 0;
    int p0;
    int d0;

    always @(negedge clk) begin
        if (match_pulse) pulse_total++;
        if (done)        done_total++;
    end

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [15:0] limit;
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          nwords;
        bit          do_abort;
        int          exp_count;
        int          exp_first;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic begin_scan(input logic [7:0] pat, input logic [3:0] len, input logic [15:0] lim);
        p0 = pulse_total;
        d0 = done_total;
        pattern = pat;
        pat_len = len;
        match_limit = lim;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic abort_scan();
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic end_scan(input string tag, input int exp_count, input int exp_first);
        int n = 0;
        while (done_total == d0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, " count"},  match_count, exp_count);
        check({tag, " pulses"}, pulse_total - p0, exp_count);
        check({tag, " done"},   done_total - d0, 1);
        check({tag, " idle"},   {busy, in_ready}, 2'b00);
`ifdef SEQ_SCAN_FIRST_POS_EN
        check({tag, " first_pos"}, first_pos, exp_first);
`else
        if (exp_first < -1) $display("unexpected first position %0d", exp_first);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        pattern = '0; pat_len = '0; match_limit = '0; in_data = '0;

        //             pat    len    limit   w0     w1     nw  abort cnt first
        vecs[0] = '{8'h0B, 4'd4,  16'd0, 8'hB6, 8'h00, 1, 1'b1, 2, 3};
        vecs[1] = '{8'h0B, 4'd4,  16'd0, 8'h01, 8'h60, 2, 1'b1, 1, 10};
        vecs[2] = '{8'h03, 4'd2,  16'd1, 8'hFF, 8'h00, 1, 1'b0, 1, 1};
        vecs[3] = '{8'h00, 4'd1,  16'd0, 8'h0F, 8'h00, 1, 1'b1, 4, 0};
        vecs[4] = '{8'h01, 4'd0,  16'd0, 8'hA5, 8'h00, 1, 1'b1, 4, 0};
        vecs[5] = '{8'hA5, 4'd15, 16'd0, 8'hA5, 8'hA5, 2, 1'b1, 2, 7};
        vecs[6] = '{8'h03, 4'd2,  16'd3, 8'hFF, 8'h00, 1, 1'b0, 3, 1};
        vecs[7] = '{8'h05, 4'd3,  16'd0, 8'h55, 8'h55, 2, 1'b1, 7, 3};
        vecs[8] = '{8'h00, 4'd4,  16'd0, 8'h0F, 8'h00, 1, 1'b1, 1, 3};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst in_ready",    in_ready, 1'b0);
        check("rst busy",        busy, 1'b0);
        check("rst match_pulse", match_pulse, 1'b0);
        check("rst done",        done, 1'b0);
        check("rst match_count", match_count, 16'd0);
`ifdef SEQ_SCAN_FIRST_POS_EN
        check("rst first_pos",   first_pos, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 9; i++) begin
            begin_scan(vecs[i].pat, vecs[i].len, vecs[i].limit);
            for (int w = 0; w < vecs[i].nwords; w++)
                send_word(w == 0 ? vecs[i].w0 : vecs[i].w1);
            if (vecs[i].do_abort) abort_scan();
            end_scan($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_first);
        end

        // Stall in LOAD with in_valid low; a start while busy must not relatch the pattern.
        begin_scan(8'h0B, 4'd4, 16'd0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall in_ready c%0d", c), in_ready, 1'b1);
            check($sformatf("stall count c%0d", c), match_count, 16'd0);
            start = (c == 2);
            pattern = (c == 2) ? 8'hFF : 8'h0B;
            @(negedge clk);
        end
        start = 1'b0;
        check("stall busy", busy, 1'b1);
        send_word(8'hB6);
`ifdef SEQ_SCAN_FIRST_POS_EN
        check("stall first_pos early", first_pos, 32'hFFFF_FFFF);
`endif
        abort_scan();
        end_scan("stall", 2, 3);

        // Reset in the middle of SHIFT, then a fresh scan.
        begin_scan(8'h03, 4'd2, 16'd0);
        send_word(8'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy",        busy, 1'b0);
        check("midrst in_ready",    in_ready, 1'b0);
        check("midrst match_pulse", match_pulse, 1'b0);
        check("midrst done",        done, 1'b0);
        check("midrst match_count", match_count, 16'd0);
        @(negedge clk);
        check("midrst still idle", {busy, match_pulse}, 2'b00);
        begin_scan(8'h0B, 4'd4, 16'd0);
        check("rescan count", match_count, 16'd0);
        send_word(8'h01);
        abort_scan();
        end_scan("rescan", 0, -1);

        // Abort asserted in the same cycle the limit is reached.
        begin_scan(8'h03, 4'd2, 16'd1);
        send_word(8'hFF);
        begin
            int n = 0;
            while (!match_pulse && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        end_scan("abort+limit", 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
